fpa_seq_addsub: RTL and testbench

- Multi-cycle IEEE-754 binary32 adder/subtractor with valid/ready handshakes on both sides.
- It is the responder to the fpa operand-sweep stimulus: it accepts operand pairs from an initiator and returns bit-exact sums matching binary32 round-to-nearest-even.
- One operation in flight at a time; fixed compute latency; result held until consumed.

---
 rtl/fpa_pkg.sv | 52 +++++
 rtl/fpa_align_shift.sv | 20 ++
 rtl/fpa_seq_addsub.sv | 262 ++++++++++++++++++++++++++
 tb/tb_fpa_seq_addsub.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/fpa_pkg.sv
// Shared types, constants and helpers for the sequential binary32 adder/subtractor.
package fpa_pkg;

  localparam int FP_EXP_W = 8;
  localparam int FP_MAN_W = 23;
  localparam int DP_W     = 27;
  localparam int SUM_W    = 28;

  localparam logic [31:0] QNAN_CANON = 32'h7FC0_0000;
  localparam logic [31:0] POS_INF    = 32'h7F80_0000;
  localparam logic [31:0] NEG_INF    = 32'hFF80_0000;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] man;
  } fp32_t;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ALIGN = 3'd1,
    S_ADD   = 3'd2,
    S_NORM  = 3'd3,
    S_ROUND = 3'd4,
    S_HOLD  = 3'd5
  } fpa_state_e;

  typedef struct packed {
    logic invalid;
    logic overflow;
    logic underflow;
    logic inexact;
  } fpa_flags_t;

  function automatic logic [4:0] lzc28(input logic [27:0] v);
    logic [4:0] n;
    logic       found;
    n     = 5'd0;
    found = 1'b0;
    for (int i = 27; i >= 0; i--) begin
      if (!found) begin
        if (v[i]) begin
          found = 1'b1;
        end else begin
          n = n + 5'd1;
        end
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/fpa_align_shift.sv
// Right barrel shifter for the smaller operand; every bit pushed out is folded into bit 0.
module fpa_align_shift (
  input  logic [26:0] data_i,
  input  logic [7:0]  shamt_i,
  output logic [26:0] data_o
);

  logic [26:0] shifted_s;
  logic [26:0] lost_mask_s;
  logic        sticky_s;

  // Shift amounts of 27 or more leave only the sticky bit.
  always_comb begin
    shifted_s   = data_i >> shamt_i;
    lost_mask_s = ~({27{1'b1}} << shamt_i);
    sticky_s    = |(data_i & lost_mask_s);
    data_o      = {shifted_s[26:1], shifted_s[0] | sticky_s};
  end

endmodule

// File: rtl/fpa_seq_addsub.sv
// Multi-cycle binary32 add/subtract, round-to-nearest-even, one operation in flight,
// fixed four-cycle latency from accept to out_valid, result held until consumed.
module fpa_seq_addsub
  import fpa_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   op,
  input  logic [EXP_W+MAN_W:0]   number_A,
  input  logic [EXP_W+MAN_W:0]   number_B,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   number_out,
  output logic [3:0]             out_flags
);

  fpa_state_e state_q, state_d;

  fp32_t       a_q, b_q;
  logic        spec_q, spec_d;
  logic [31:0] spec_res_q, spec_res_d;
  fpa_flags_t  spec_flags_q, spec_flags_d;
  logic        sign_q, sign_d;
  logic        sub_q, sub_d;
  logic [9:0]  exp_q, exp_d;
  logic [26:0] mx_q, mx_d;
  logic [26:0] my_q, my_d;
  logic [27:0] sum_q, sum_d;
  logic [26:0] nm_q, nm_d;
  logic [9:0]  ne_q, ne_d;
  logic [31:0] out_q, out_d;
  fpa_flags_t  flags_q, flags_d;

  fp32_t       x_s, y_s;
  logic [7:0]  ex_eff_s, ey_eff_s, shamt_s;
  logic [26:0] y_shifted_s;

  logic        a_nan_s, b_nan_s, a_inf_s, b_inf_s, a_zero_s, b_zero_s;

  logic [4:0]  lz_s;
  logic [9:0]  lz27_s, emax_s, sh_s;

  logic [23:0] mant24_s;
  logic        g_s, r_s, st_s, rup_s, inexact_s;
  logic [24:0] mr_s;
  logic [9:0]  ef_s;
  logic [22:0] mf_s;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = in_valid ? S_ALIGN : S_IDLE;
      S_ALIGN: state_d = S_ADD;
      S_ADD:   state_d = S_NORM;
      S_NORM:  state_d = S_ROUND;
      S_ROUND: state_d = S_HOLD;
      S_HOLD:  state_d = out_ready ? S_IDLE : S_HOLD;
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from the state register.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      S_IDLE:  in_ready  = 1'b1;
      S_HOLD:  out_valid = 1'b1;
      default: begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
      end
    endcase
  end

  // ALIGN: order by magnitude, align the smaller operand and resolve special operands.
  always_comb begin
    if (a_q[30:0] >= b_q[30:0]) begin
      x_s = a_q;
      y_s = b_q;
    end else begin
      x_s = b_q;
      y_s = a_q;
    end
    ex_eff_s = (x_s.exp == 8'd0) ? 8'd1 : x_s.exp;
    ey_eff_s = (y_s.exp == 8'd0) ? 8'd1 : y_s.exp;
    shamt_s  = ex_eff_s - ey_eff_s;
    sign_d   = x_s.sign;
    sub_d    = x_s.sign ^ y_s.sign;
    exp_d    = {2'b00, ex_eff_s};
    mx_d     = {(x_s.exp != 8'd0), x_s.man, 3'b000};
    my_d     = y_shifted_s;

    a_nan_s  = (a_q.exp == 8'hFF) && (a_q.man != 23'd0);
    b_nan_s  = (b_q.exp == 8'hFF) && (b_q.man != 23'd0);
    a_inf_s  = (a_q.exp == 8'hFF) && (a_q.man == 23'd0);
    b_inf_s  = (b_q.exp == 8'hFF) && (b_q.man == 23'd0);
    a_zero_s = (a_q[30:0] == 31'd0);
    b_zero_s = (b_q[30:0] == 31'd0);

    spec_d       = 1'b1;
    spec_res_d   = 32'd0;
    spec_flags_d = '0;
    if (a_nan_s) begin
      spec_res_d           = a_q | 32'h0040_0000;
      spec_flags_d.invalid = ~a_q.man[22];
    end else if (b_nan_s) begin
      spec_res_d           = b_q | 32'h0040_0000;
      spec_flags_d.invalid = ~b_q.man[22];
    end else if (a_inf_s && b_inf_s && (a_q.sign != b_q.sign)) begin
      spec_res_d           = QNAN_CANON;
      spec_flags_d.invalid = 1'b1;
    end else if (a_inf_s) begin
      spec_res_d = a_q;
    end else if (b_inf_s) begin
      spec_res_d = b_q;
    end else if (a_zero_s && b_zero_s) begin
      // Only two negative zeros keep the sign; every other zero pair gives +0.
      spec_res_d = {a_q.sign & b_q.sign, 31'd0};
    end else begin
      spec_d = 1'b0;
    end
  end

  fpa_align_shift u_align_shift (
    .data_i  ({(y_s.exp != 8'd0), y_s.man, 3'b000}),
    .shamt_i (shamt_s),
    .data_o  (y_shifted_s)
  );

  // ADD: |X| >= |Y| so the subtraction never goes negative.
  always_comb begin
    if (sub_q) begin
      sum_d = {1'b0, mx_q} - {1'b0, my_q};
    end else begin
      sum_d = {1'b0, mx_q} + {1'b0, my_q};
    end
  end

  // NORM: fold a carry, or left-justify without pushing the exponent below 1.
  always_comb begin
    lz_s   = lzc28(sum_q);
    lz27_s = {5'd0, lz_s} - 10'd1;
    emax_s = exp_q - 10'd1;
    sh_s   = (lz27_s > emax_s) ? emax_s : lz27_s;
    if (sum_q[27]) begin
      nm_d = {sum_q[27:2], sum_q[1] | sum_q[0]};
      ne_d = exp_q + 10'd1;
    end else begin
      nm_d = sum_q[26:0] << sh_s;
      ne_d = exp_q - sh_s;
    end
  end

  // ROUND: nearest-even on guard/round/sticky, then encode and raise flags.
  always_comb begin
    mant24_s  = nm_q[26:3];
    g_s       = nm_q[2];
    r_s       = nm_q[1];
    st_s      = nm_q[0];
    inexact_s = g_s | r_s | st_s;
    rup_s     = g_s & (r_s | st_s | mant24_s[0]);
    mr_s      = {1'b0, mant24_s} + {24'd0, rup_s};
    if (mr_s[24]) begin
      ef_s = ne_q + 10'd1;
      mf_s = mr_s[23:1];
    end else if (mr_s[23]) begin
      ef_s = ne_q;
      mf_s = mr_s[22:0];
    end else begin
      ef_s = 10'd0;
      mf_s = mr_s[22:0];
    end

    flags_d = '0;
    if (spec_q) begin
      out_d   = spec_res_q;
      flags_d = spec_flags_q;
    end else if (ef_s >= 10'd255) begin
      out_d            = sign_q ? NEG_INF : POS_INF;
      flags_d.overflow = 1'b1;
      flags_d.inexact  = 1'b1;
    end else if (mr_s == 25'd0) begin
      out_d = 32'd0;
    end else begin
      out_d             = {sign_q, ef_s[7:0], mf_s};
      flags_d.inexact   = inexact_s;
      flags_d.underflow = inexact_s & (ef_s == 10'd0);
    end
  end

  // Datapath registers, each stage loaded only in its own state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q          <= '0;
      b_q          <= '0;
      spec_q       <= 1'b0;
      spec_res_q   <= 32'd0;
      spec_flags_q <= '0;
      sign_q       <= 1'b0;
      sub_q        <= 1'b0;
      exp_q        <= 10'd0;
      mx_q         <= 27'd0;
      my_q         <= 27'd0;
      sum_q        <= 28'd0;
      nm_q         <= 27'd0;
      ne_q         <= 10'd0;
      out_q        <= 32'd0;
      flags_q      <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            a_q <= number_A;
            b_q <= number_B ^ {op, 31'd0};
          end
        end
        S_ALIGN: begin
          spec_q       <= spec_d;
          spec_res_q   <= spec_res_d;
          spec_flags_q <= spec_flags_d;
          sign_q       <= sign_d;
          sub_q        <= sub_d;
          exp_q        <= exp_d;
          mx_q         <= mx_d;
          my_q         <= my_d;
        end
        S_ADD: sum_q <= sum_d;
        S_NORM: begin
          nm_q <= nm_d;
          ne_q <= ne_d;
        end
        S_ROUND: begin
          out_q   <= out_d;
          flags_q <= flags_d;
        end
        default: begin
          out_q <= out_q;
        end
      endcase
    end
  end

  assign number_out = out_q;
  assign out_flags  = flags_q;

endmodule

// File: tb/tb_fpa_seq_addsub.sv
// Directed bench for fpa_seq_addsub: hand-computed binary32 results, latency, hold and reset behaviour.
module tb_fpa_seq_addsub;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        op;
  logic [31:0] number_A;
  logic [31:0] number_B;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] number_out;
  logic [3:0]  out_flags;

  int checks;
  int errors;

  fpa_seq_addsub dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .op         (op),
    .number_A   (number_A),
    .number_B   (number_B),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .number_out (number_out),
    .out_flags  (out_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Full transaction: accept, measure latency, check result and flags, then consume.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic o, input logic [31:0] exp_res, input logic [3:0] exp_fl);
    int lat;
    lat = 0;
    @(negedge clk);
    number_A = a;
    number_B = b;
    op       = o;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat = i;
        break;
      end
    end
    check({tag, "_latency"}, lat, 32'd4);
    check({tag, "_result"}, number_out, exp_res);
    check({tag, "_flags"}, {28'd0, out_flags}, {28'd0, exp_fl});
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check({tag, "_valid_drop"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    int lat;
    logic seen_valid;
    checks     = 0;
    errors     = 0;
    rst        = 1'b1;
    in_valid   = 1'b0;
    op         = 1'b0;
    number_A   = 32'd0;
    number_B   = 32'd0;
    out_ready  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_number_out", number_out, 32'd0);
    check("reset_flags", {28'd0, out_flags}, 32'd0);
    check("reset_in_ready", {31'd0, in_ready}, 32'd1);

    run_op("add_1_2",      32'h3F80_0000, 32'h4000_0000, 1'b0, 32'h4040_0000, 4'b0000);
    run_op("overflow",     32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, 32'h7F80_0000, 4'b0101);
    run_op("inf_minus_inf",32'h7F80_0000, 32'hFF80_0000, 1'b0, 32'h7FC0_0000, 4'b1000);
    run_op("one_sub_one",  32'h3F80_0000, 32'h3F80_0000, 1'b1, 32'h0000_0000, 4'b0000);
    run_op("sub_tiny",     32'h0000_0001, 32'h0000_0001, 1'b0, 32'h0000_0002, 4'b0000);
    run_op("sub_to_norm",  32'h007F_FFFF, 32'h0000_0001, 1'b0, 32'h0080_0000, 4'b0000);
    run_op("tie_even",     32'h3F80_0000, 32'h3380_0000, 1'b0, 32'h3F80_0000, 4'b0001);
    run_op("tie_odd",      32'h3F80_0001, 32'h3380_0000, 1'b0, 32'h3F80_0002, 4'b0001);
    run_op("snan_a",       32'h7FA0_0000, 32'h3F80_0000, 1'b0, 32'h7FE0_0000, 4'b1000);
    run_op("negzero_sum",  32'h8000_0000, 32'h8000_0000, 1'b0, 32'h8000_0000, 4'b0000);
    run_op("zero_plus_x",  32'h0000_0000, 32'h3F80_0000, 1'b0, 32'h3F80_0000, 4'b0000);
    run_op("two_sub_one",  32'h4000_0000, 32'h3F80_0000, 1'b1, 32'h3F80_0000, 4'b0000);

    // Hold the result for six cycles with a stray in_valid pulse in the middle.
    @(negedge clk);
    number_A = 32'h3F80_0000;
    number_B = 32'h4000_0000;
    op       = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat = i;
        break;
      end
    end
    check("hold_latency", lat, 32'd4);
    for (int c = 0; c < 6; c++) begin
      if (c == 3) begin
        number_A = 32'h4000_0000;
        number_B = 32'h4000_0000;
        in_valid = 1'b1;
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
      check("hold_number_out", number_out, 32'h4040_0000);
      check("hold_in_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    seen_valid = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      #1;
      seen_valid = seen_valid | out_valid;
    end
    check("stray_not_captured", {31'd0, seen_valid}, 32'd0);
    check("idle_after_hold", {31'd0, in_ready}, 32'd1);

    // Reset while the operation sits in NORM.
    @(negedge clk);
    number_A = 32'h3F80_0000;
    number_B = 32'h4000_0000;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    seen_valid = out_valid;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      #1;
      seen_valid = seen_valid | out_valid;
    end
    check("rst_no_valid", {31'd0, seen_valid}, 32'd0);

    run_op("after_reset",  32'h3F80_0000, 32'h4000_0000, 1'b0, 32'h4040_0000, 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
